// File: rtl/io_pkg.sv
// Shared definitions for the CPU I/O bus: size codes, initiator states and
// the legality / store-masking rules applied before a request reaches the bus.
package io_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } io_state_t;

    // Unsigned sizes only make sense for loads; stores have no extension.
    function automatic logic io_size_legal(input logic [2:0] size, input logic write);
        logic legal;
        case (size)
            SZ_B, SZ_H, SZ_W: legal = 1'b1;
            SZ_BU, SZ_HU:     legal = !write;
            default:          legal = 1'b0;
        endcase
        return legal;
    endfunction

    function automatic logic [31:0] io_store_mask(input logic [2:0] size, input logic [31:0] wdata);
        logic [31:0] masked;
        case (size)
            SZ_B:    masked = {24'h0, wdata[7:0]};
            SZ_H:    masked = {16'h0, wdata[15:0]};
            default: masked = wdata;
        endcase
        return masked;
    endfunction

endpackage

// File: rtl/io_bus_initiator_if.sv
// Board-level I/O bus between the initiator (master) and the responder (slave).
interface io_bus_initiator_if;

    logic [31:0] io_address;
    logic [31:0] io_write_value;
    logic [2:0]  io_data_size;
    logic [31:0] io_read_value;
    logic        io_read_en;
    logic        io_write_en;

    modport master (
        output io_address,
        output io_write_value,
        output io_data_size,
        output io_read_en,
        output io_write_en,
        input  io_read_value
    );

    modport slave (
        input  io_address,
        input  io_write_value,
        input  io_data_size,
        input  io_read_en,
        input  io_write_en,
        output io_read_value
    );

endinterface

// File: rtl/io_load_format.sv
// Load data formatting: truncate a right-justified word to the access size and
// sign- or zero-extend it. Shared with the memory-stage load path.
module io_load_format
    import io_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [31:0] raw_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = '0;
        case (size_i)
            SZ_B:    data_o = {{24{raw_i[7]}}, raw_i[7:0]};
            SZ_H:    data_o = {{16{raw_i[15]}}, raw_i[15:0]};
            SZ_W:    data_o = raw_i;
            SZ_BU:   data_o = {24'h0, raw_i[7:0]};
            SZ_HU:   data_o = {16'h0, raw_i[15:0]};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/io_bus_initiator.sv
// Single-outstanding load/store initiator for the board I/O bus with
// programmable wait states and up-front rejection of illegal size codes.
module io_bus_initiator
    import io_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_wdata,
    input  logic [2:0]                 req_size,
    output logic                       resp_valid,
    output logic [31:0]                resp_rdata,
    output logic                       resp_error,
    io_bus_initiator_if.master         bus
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);
    localparam logic       NO_WAIT   = (WAIT_CYCLES == 0);

    io_state_t   state_q;
    logic [3:0]  wait_q;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  size_q;
    logic        rd_en_q;
    logic        wr_en_q;
    logic        resp_valid_q;
    logic        resp_error_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        req_legal;
    logic        last_access;
    logic        next_is_last;
    logic [31:0] load_data;

    assign req_ready    = (state_q == IDLE) && rst_n;
    assign accept       = req_valid && req_ready;
    assign req_legal    = io_size_legal(req_size, req_write);
    assign last_access  = (wait_q == WAIT_LAST);
    assign next_is_last = (({1'b0, wait_q} + 5'd1) == {1'b0, WAIT_LAST});

    io_load_format u_load_format (
        .size_i (size_q),
        .raw_i  (bus.io_read_value),
        .data_o (load_data)
    );

    // Write strobe is raised one edge early so it is registered yet lands
    // exactly on the final ACCESS cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            rdata_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q  <= req_addr;
                        wdata_q <= io_store_mask(req_size, req_wdata);
                        size_q  <= req_size;
                        write_q <= req_write;
                        wait_q  <= '0;
                        if (req_legal) begin
                            state_q <= ACCESS;
                            rd_en_q <= !req_write;
                            wr_en_q <= req_write && NO_WAIT;
                        end else begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= 1'b1;
                            rdata_q      <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (last_access) begin
                        state_q      <= RESP;
                        rd_en_q      <= 1'b0;
                        wr_en_q      <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= 1'b0;
                        rdata_q      <= write_q ? '0 : load_data;
                    end else begin
                        wait_q  <= wait_q + 4'd1;
                        wr_en_q <= write_q && next_is_last;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign resp_valid         = resp_valid_q;
    assign resp_rdata         = rdata_q;
    assign resp_error         = resp_error_q;
    assign bus.io_address     = addr_q;
    assign bus.io_write_value = wdata_q;
    assign bus.io_data_size   = size_q;
    assign bus.io_read_en     = rd_en_q;
    assign bus.io_write_en    = wr_en_q;

endmodule
